// File: rtl/psc_trigger_rx.sv
// psc_trigger_rx: UART-style receiver for the PSC trigger link, pulses trigger_out_o on TRIGGER_CODE.
// Define PSC_RX_PARITY_EN to add an even-parity bit between the data and the stop bit.
module psc_trigger_rx #(
  parameter int          CLKS_PER_BIT = 50,
  parameter logic [7:0]  TRIGGER_CODE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       psc_input_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       trigger_out_o,
  output logic       frame_error_o,
  output logic       busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef PSC_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  logic par_err_q;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
  state_t        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          trig_q;
  logic          fe_q;
  logic          rxs;
  assign rxs           = sync_q[1];
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign trigger_out_o = trig_q;
  assign frame_error_o = fe_q;
  assign busy_o        = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      trig_q     <= 1'b0;
      fe_q       <= 1'b0;
`ifdef PSC_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[0], psc_input_i};
      rx_valid_q <= 1'b0;
      trig_q     <= 1'b0;
      fe_q       <= 1'b0;
      clk_cnt_q  <= (clk_cnt_q == LAST) ? '0 : clk_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          if (!rxs) state_q <= START;
        end
        // Half-bit offset here puts every later sample at bit centre.
        START: if (clk_cnt_q == MID) begin
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          state_q   <= rxs ? IDLE : DATA;
        end
        DATA: if (clk_cnt_q == LAST) begin
          shift_q   <= {rxs, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef PSC_RX_PARITY_EN
          if (bit_cnt_q == 3'd7) state_q <= PARITY;
`else
          if (bit_cnt_q == 3'd7) state_q <= STOP;
`endif
        end
`ifdef PSC_RX_PARITY_EN
        PARITY: if (clk_cnt_q == LAST) begin
          par_err_q <= (^shift_q) ^ rxs;
          state_q   <= STOP;
        end
`endif
        STOP: if (clk_cnt_q == LAST) begin
          if (!rxs) begin
            fe_q    <= 1'b1;
            state_q <= BREAK;
          end
`ifdef PSC_RX_PARITY_EN
          else if (par_err_q) begin
            fe_q    <= 1'b1;
            state_q <= IDLE;
          end
`endif
          else begin
            rx_data_q  <= shift_q;
            rx_valid_q <= 1'b1;
            trig_q     <= shift_q == TRIGGER_CODE;
            state_q    <= IDLE;
          end
        end
        // A line stuck low must return high before a new start is accepted.
        BREAK: if (rxs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
